// File: rtl/fifo_wr_serializer_if.sv
// fifo_wr_serializer_if
// Bundles the wide input stream and the FIFO write port of the write-side
// serialiser.
//   s_valid/s_ready/s_data/s_last/s_nbytes : wide beat stream (lane 0 = LSBs)
//   wfull                                   : FIFO full flag (wclk domain)
//   winc/wdata                              : one FIFO-width write per cycle
// The master modport is the environment, meaning the beat source plus the
// FIFO. The slave modport is the serialiser.
interface fifo_wr_serializer_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int LANES      = 4
);
  localparam int NBW = $clog2(LANES) + 1;

  logic                        s_valid;
  logic                        s_ready;
  logic [LANES*FIFO_WIDTH-1:0] s_data;
  logic                        s_last;
  logic [NBW-1:0]              s_nbytes;
  logic                        wfull;
  logic                        winc;
  logic [FIFO_WIDTH-1:0]       wdata;

  modport master (
    output s_valid, s_data, s_last, s_nbytes, wfull,
    input  s_ready, winc, wdata
  );

  modport slave (
    input  s_valid, s_data, s_last, s_nbytes, wfull,
    output s_ready, winc, wdata
  );
endinterface

// File: rtl/fifo_wr_serializer.sv
// fifo_wr_serializer
// Write-side width converter in front of the async FIFO (wclk domain). It
// accepts LANES*FIFO_WIDTH-bit beats and emits one FIFO word per cycle,
// lane 0 first. Short final beats send only s_nbytes lanes. It counts
// completed frames.
// Ports:
//   wclk, wrst_n : write clock, asynchronous active-low reset
//   bus          : slave side of fifo_wr_serializer_if (stream in, FIFO out)
//   frame_cnt    : completed frames, wraps modulo 2^CNT_WIDTH
//   busy         : holding register occupied (same as winc)
module fifo_wr_serializer #(
  parameter int FIFO_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  fifo_wr_serializer_if.slave  bus,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic                 busy
);
  localparam int LW  = $clog2(LANES);
  localparam int NBW = LW + 1;

  typedef enum logic {EMPTY, SEND} state_t;

  state_t                               state_q, state_d;
  logic [LANES-1:0][FIFO_WIDTH-1:0]     hold_word;
  logic                                 hold_last;
  logic [LW-1:0]                        lane;
  logic [LW-1:0]                        last_lane;
  logic                                 xfer;
  logic                                 final_xfer;
  logic                                 accept;

  // Index of the last lane to send. Full beats and out-of-range byte counts
  // use every lane.
  function automatic logic [LW-1:0] final_lane(input logic           last,
                                               input logic [NBW-1:0] nbytes);
    logic [NBW-1:0] nb;
    nb = NBW'(LANES);
    if (last && (nbytes != '0) && (nbytes <= NBW'(LANES))) nb = nbytes;
    return LW'(nb - 1'b1);
  endfunction

  // While the FIFO is full, winc stays asserted. The FIFO drops the request,
  // so the lane pointer simply holds and nothing is lost or duplicated.
  always_comb begin
    state_d     = state_q;
    bus.winc    = 1'b0;
    xfer        = 1'b0;
    final_xfer  = 1'b0;
    bus.s_ready = 1'b0;
    accept      = 1'b0;
    case (state_q)
      EMPTY: begin
        bus.s_ready = 1'b1;
        accept      = bus.s_valid;
        if (accept) state_d = SEND;
      end
      SEND: begin
        bus.winc    = 1'b1;
        xfer        = !bus.wfull;
        final_xfer  = xfer && (lane == last_lane);
        // A new beat can load in the same cycle as the final-lane write, so
        // back-to-back beats stream with no bubble.
        bus.s_ready = final_xfer;
        accept      = bus.s_valid && final_xfer;
        if (final_xfer && !accept) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  assign bus.wdata = hold_word[lane];
  assign busy      = bus.winc;

  // Holding register stage
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q   <= EMPTY;
      hold_word <= '0;
      hold_last <= 1'b0;
      lane      <= '0;
      last_lane <= '0;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hold_word <= bus.s_data;
        hold_last <= bus.s_last;
        lane      <= '0;
        last_lane <= final_lane(bus.s_last, bus.s_nbytes);
      end else if (xfer && !final_xfer) begin
        lane <= lane + 1'b1;
      end
      if (final_xfer && hold_last) frame_cnt <= frame_cnt + 1'b1;
    end
  end
endmodule
